// File: rtl/iigs_io_bus.sv
// $C0xx I/O decoder for banks 00/01/E0/E1: routes accesses to req/ack peripheral
// channels (with stall and timeout) or to a local soft-switch register file.
module iigs_io_bus #(
    parameter int                       NUM_CH       = 4,
    parameter logic [NUM_CH*8-1:0]      CH_BASE      = {NUM_CH{8'h00}},
    parameter logic [NUM_CH*8-1:0]      CH_MASK      = {NUM_CH{8'hFF}},
    parameter int                       TIMEOUT      = 15,
    parameter logic [7:0]               TIMEOUT_DATA = 8'hFF,
    parameter logic [7:0]               LREG_BASE    = 8'h20,
    parameter int                       LREG_DEPTH   = 32,
    parameter logic [LREG_DEPTH*8-1:0]  LREG_INIT    = '0
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     cen,
    input  logic [7:0]               bank,
    input  logic [15:0]              addr,
    input  logic                     valid,
    input  logic                     wr,
    input  logic                     io_off,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     io_hit,
    output logic                     rdy,
    output logic [NUM_CH-1:0]        ch_req,
    output logic                     ch_wr,
    output logic [7:0]               ch_addr,
    output logic [7:0]               ch_wdata,
    input  logic [NUM_CH-1:0]        ch_ack,
    input  logic [NUM_CH*8-1:0]      ch_rdata,
    output logic [LREG_DEPTH*8-1:0]  lreg,
    output logic [7:0]               err_cnt
);

    // state | meaning
    // IDLE  | decode; local/unmapped accesses served here
    // REQ   | one-clk request pulse to the selected channel
    // WAIT  | waiting for ack or timeout, CPU stalled
    // DONE  | data ready, held until the CPU consumes it on cen

    localparam int         IW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int         LW       = (LREG_DEPTH > 1) ? $clog2(LREG_DEPTH) : 1;
    localparam logic [8:0] LREG_END = 9'(LREG_BASE) + 9'(LREG_DEPTH);
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t          state;
    logic            bank_ok;
    logic            ch_any;
    logic [IW-1:0]   ch_sel;
    logic [IW-1:0]   ch_idx;
    logic            loc_hit;
    logic [LW-1:0]   lidx;
    logic            ch_go;
    logic            loc_acc;
    logic            unmapped;
    logic [7:0]      cnt;
    logic [7:0]      cnt_inc;

    assign bank_ok = (bank == 8'h00) | (bank == 8'h01) | (bank == 8'hE0) | (bank == 8'hE1);
    assign io_hit  = valid & ~io_off & (addr[15:8] == 8'hC0) & bank_ok;

    // Scan from the top so the lowest matching channel is the one left selected.
    always_comb begin
        ch_any = 1'b0;
        ch_sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if ((addr[7:0] & CH_MASK[8*i +: 8]) == (CH_BASE[8*i +: 8] & CH_MASK[8*i +: 8])) begin
                ch_any = 1'b1;
                ch_sel = IW'(i);
            end
        end
    end

    assign loc_hit  = ({1'b0, addr[7:0]} >= {1'b0, LREG_BASE}) && ({1'b0, addr[7:0]} < LREG_END);
    assign lidx     = LW'(addr[7:0] - LREG_BASE);
    assign ch_go    = io_hit & ch_any;
    assign loc_acc  = io_hit & ~ch_any & loc_hit;
    assign unmapped = io_hit & ~ch_any & ~loc_hit;
    assign cnt_inc  = cnt + 8'd1;

    // The stall must take effect in the same cycle the channel access is presented.
    assign rdy = reset | ~((state == REQ) | (state == WAIT) | ((state == IDLE) & ch_go));

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            lreg <= LREG_INIT;
        end else if (cen & loc_acc & wr) begin
            lreg[8*lidx +: 8] <= din;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ch_req   <= '0;
            ch_wr    <= 1'b0;
            ch_addr  <= 8'h00;
            ch_wdata <= 8'h00;
            ch_idx   <= '0;
            cnt      <= 8'h00;
            dout     <= 8'h00;
            err_cnt  <= 8'h00;
        end else begin
            ch_req <= '0;
            case (state)
                IDLE: begin
                    if (cen & ch_go) begin
                        state    <= REQ;
                        ch_req   <= NUM_CH'(1) << ch_sel;
                        ch_wr    <= wr;
                        ch_addr  <= addr[7:0];
                        ch_wdata <= din;
                        ch_idx   <= ch_sel;
                        cnt      <= 8'h00;
                    end else if (loc_acc & ~wr) begin
                        dout <= lreg[8*lidx +: 8];
                    end else if (unmapped & ~wr) begin
                        dout <= 8'h00;
                    end
                end
                REQ, WAIT: begin
                    // cnt_inc counts clks since REQ began, including this one
                    cnt <= cnt_inc;
                    if (ch_ack[ch_idx]) begin
                        state <= DONE;
                        if (!ch_wr) dout <= ch_rdata[8*ch_idx +: 8];
                    end else if (cnt_inc == TO_LIMIT) begin
                        state <= DONE;
                        if (!ch_wr) dout <= TIMEOUT_DATA;
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    end else begin
                        state <= WAIT;
                    end
                end
                DONE: begin
                    if (cen) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
